// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: pipelined N:1 binary mux tree with valid, channel tag, auto-scan and flush
module mux_tree_pipe #(
  parameter int WIDTH = 1,
  parameter int SEL_W = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [(2**SEL_W)*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]            sel,
  input  logic                        in_valid,
  input  logic                        scan_en,
  input  logic                        flush,
  output logic [WIDTH-1:0]            y,
  output logic                        y_valid,
  output logic [SEL_W-1:0]            y_sel,
  output logic [SEL_W-1:0]            scan_cnt
);
  logic [SEL_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_v;
  logic [SEL_W-1:0] w_eff_sel;

  assign w_eff_sel = scan_en ? r_cnt : sel;

  // scan counter advances once per accepted scan sample and wraps naturally at N
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (flush) r_cnt <= '0;
    else if (scan_en && in_valid) r_cnt <= r_cnt + 1'b1;

  // valid shifts one stage per cycle; flush kills every in-flight sample including the incoming one
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_v <= '0;
    else if (flush) r_v <= '0;
    else r_v <= SEL_W'({r_v, in_valid});

  for (genvar k = 0; k < SEL_W; k++) begin : g_st
    localparam int M = 2**(SEL_W-1-k);
    logic [M*WIDTH-1:0] r_d;
    logic [SEL_W-1:0]   r_tag;
    logic [M*WIDTH-1:0] w_d;
    logic [SEL_W-1:0]   w_tag;
    if (k == 0) begin : g_in
      assign w_tag = w_eff_sel;
      for (genvar j = 0; j < M; j++) begin : g_n
        assign w_d[j*WIDTH +: WIDTH] = w_eff_sel[0] ? din[(2*j+1)*WIDTH +: WIDTH] : din[2*j*WIDTH +: WIDTH];
      end
    end else begin : g_mid
      assign w_tag = g_st[k-1].r_tag;
      for (genvar j = 0; j < M; j++) begin : g_n
        assign w_d[j*WIDTH +: WIDTH] = w_tag[k] ? g_st[k-1].r_d[(2*j+1)*WIDTH +: WIDTH] : g_st[k-1].r_d[2*j*WIDTH +: WIDTH];
      end
    end
    // the full select tag rides with the data and supplies the select bit for each later level
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        r_d   <= '0;
        r_tag <= '0;
      end else begin
        r_d   <= w_d;
        r_tag <= w_tag;
      end
  end

  assign y        = g_st[SEL_W-1].r_d;
  assign y_sel    = g_st[SEL_W-1].r_tag;
  assign y_valid  = r_v[SEL_W-1];
  assign scan_cnt = r_cnt;
endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb_mux_tree_pipe: scoreboard bench for the 8:1 x1 and 4:1 x4 configurations
module tb_mux_tree_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  din;
  logic [2:0]  sel, y_sel, scan_cnt;
  logic        in_valid, scan_en, flush, y, y_valid;
  logic [15:0] din2;
  logic [1:0]  sel2, y_sel2, scan_cnt2;
  logic        in_valid2, y_valid2;
  logic        scan_en2 = 1'b0;
  logic        flush2 = 1'b0;
  logic [3:0]  y2;

  mux_tree_pipe #(.WIDTH(1), .SEL_W(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .in_valid(in_valid), .scan_en(scan_en),
    .flush(flush), .y(y), .y_valid(y_valid), .y_sel(y_sel), .scan_cnt(scan_cnt));

  mux_tree_pipe #(.WIDTH(4), .SEL_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .din(din2), .sel(sel2), .in_valid(in_valid2), .scan_en(scan_en2),
    .flush(flush2), .y(y2), .y_valid(y_valid2), .y_sel(y_sel2), .scan_cnt(scan_cnt2));

  typedef struct {int due; logic [3:0] y; logic [2:0] s;} exp_t;
  exp_t q1[$], q2[$];
  exp_t e1, e2;
  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // drive one cycle of DUT1 inputs; when exp_out is set the sample must appear 3 cycles later
  task automatic drv(input logic [2:0] s, input logic se, input logic v, input logic fl,
                     input logic ey, input logic [2:0] es, input logic exp_out);
    sel = s; scan_en = se; in_valid = v; flush = fl;
    if (exp_out) q1.push_back('{cyc + 3, 4'(ey), es});
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  always @(negedge clk) if (rst_n) begin
    if (y_valid) begin
      if (q1.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL d1_unexpected_valid: got y_valid=1 y_sel=%0d, want y_valid=0 (cycle %0d)", y_sel, cyc);
      end else begin
        e1 = q1.pop_front();
        chk("d1_y", 32'(y), 32'(e1.y[0]));
        chk("d1_y_sel", 32'(y_sel), 32'(e1.s));
        chk("d1_latency", 32'(cyc), 32'(e1.due));
      end
    end
    if (y_valid2) begin
      if (q2.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL d2_unexpected_valid: got y_valid=1 y_sel=%0d, want y_valid=0 (cycle %0d)", y_sel2, cyc);
      end else begin
        e2 = q2.pop_front();
        chk("d2_y", 32'(y2), 32'(e2.y));
        chk("d2_y_sel", 32'(y_sel2), 32'(e2.s[1:0]));
        chk("d2_latency", 32'(cyc), 32'(e2.due));
      end
    end
  end

  logic       t2[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic       t3[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [1:0] s6[3]  = '{2'd3, 2'd0, 2'd2};
  logic [3:0] y6[3]  = '{4'hF, 4'hC, 4'hE};

  initial begin
    din = '0; sel = '0; in_valid = 1'b0; scan_en = 1'b0; flush = 1'b0;
    din2 = '0; sel2 = '0; in_valid2 = 1'b0;
    repeat (4) begin
      din = 8'($urandom); sel = 3'($urandom); in_valid = 1'b1; scan_en = 1'($urandom);
      din2 = 16'($urandom); sel2 = 2'($urandom); in_valid2 = 1'b1;
      tick();
    end
    chk("rst_y", 32'(y), 0);
    chk("rst_y_valid", 32'(y_valid), 0);
    chk("rst_y_sel", 32'(y_sel), 0);
    chk("rst_scan_cnt", 32'(scan_cnt), 0);
    chk("rst_d2_y", 32'(y2), 0);
    chk("rst_d2_y_valid", 32'(y_valid2), 0);
    in_valid = 1'b0; scan_en = 1'b0; in_valid2 = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_y_valid", 32'(y_valid), 0);
    end

    din = 8'b10111011;
    for (int i = 0; i < 8; i++) drv(3'(i), 1'b0, 1'b1, 1'b0, t2[i], 3'(i), 1'b1);
    idle(1);

    din = 8'hA5;
    for (int i = 0; i < 10; i++) drv(3'd0, 1'b1, 1'b1, 1'b0, t3[i], 3'(i), 1'b1);
    idle(4);
    chk("scan_wrap_cnt", 32'(scan_cnt), 2);

    drv(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    chk("flush_clears_cnt", 32'(scan_cnt), 0);
    drv(3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1);
    drv(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("gap_holds_cnt", 32'(scan_cnt), 1);
    drv(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1);
    idle(4);
    chk("gap_cnt", 32'(scan_cnt), 2);

    drv(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    drv(3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1);
    drv(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    drv(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    drv(3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    chk("post_flush_y_valid", 32'(y_valid), 0);
    chk("post_flush_cnt", 32'(scan_cnt), 0);
    idle(4);

    drv(3'd5, 1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 1'b1);
    drv(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    drv(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    in_valid = 1'b0; scan_en = 1'b0;
    #6 rst_n = 1'b0;
    #1;
    chk("async_rst_y", 32'(y), 0);
    chk("async_rst_y_valid", 32'(y_valid), 0);
    chk("async_rst_y_sel", 32'(y_sel), 0);
    chk("async_rst_cnt", 32'(scan_cnt), 0);
    #1 rst_n = 1'b1;
    tick();
    idle(4);

    din2 = 16'hFEDC;
    for (int i = 0; i < 3; i++) begin
      sel2 = s6[i]; in_valid2 = 1'b1;
      q2.push_back('{cyc + 2, y6[i], {1'b0, s6[i]}});
      tick();
    end
    in_valid2 = 1'b0;
    idle(4);

    chk("d1_queue_drained", 32'(q1.size()), 0);
    chk("d2_queue_drained", 32'(q2.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
